// File: rtl/matmul_issue_ctrl.sv
// ============================================================================
// matmul_issue_ctrl: two-requester round-robin issue/sequence controller for
// the 8x8 matmul block, with beat tracking, watchdog and tagged response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matmul_issue_ctrl #(
  parameter int REGIDWIDTH   = 8,
  parameter int MASK_WIDTH   = 8,
  parameter int MAT_MUL_SIZE = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*REGIDWIDTH-1:0]   req_dst,
  input  logic [2*4*MASK_WIDTH-1:0] req_masks,
  output logic                      mm_start,
  input  logic                      mm_in_progress,
  input  logic                      mm_c_data_available,
  output logic [MASK_WIDTH-1:0]     mm_mask_a_rows,
  output logic [MASK_WIDTH-1:0]     mm_mask_a_cols,
  output logic [MASK_WIDTH-1:0]     mm_mask_b_rows,
  output logic [MASK_WIDTH-1:0]     mm_mask_b_cols,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [REGIDWIDTH-1:0]     rsp_dst,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAT_MUL_SIZE + 1);
  localparam int CW = 4 * MASK_WIDTH;
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);
  localparam logic [BW-1:0] BEATS_FULL  = BW'(MAT_MUL_SIZE);
  localparam logic [TW-1:0] START_SKIP  = TW'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          state, state_next;
  logic            last_grant;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   timer;

  logic            any_valid;
  logic            grant;
  logic [CW-1:0]   sel_masks;
  logic [BW-1:0]   beat_next;
  logic [TW-1:0]   timer_inc;
  logic            timeout_hit;

  assign any_valid   = |req_valid;
  assign grant       = (&req_valid) ? ~last_grant : req_valid[1];
  assign sel_masks   = grant ? req_masks[2*CW-1:CW] : req_masks[CW-1:0];
  assign beat_next   = (mm_c_data_available && (beat_cnt != BEATS_FULL)) ?
                       beat_cnt + 1'b1 : beat_cnt;
  // Watchdog fires on the cycle whose increment would reach the limit.
  assign timer_inc   = timer + 1'b1;
  assign timeout_hit = (timer_inc == TIMER_LIMIT);

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    mm_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          req_ready  = grant ? 2'b10 : 2'b01;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mm_start   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (timeout_hit) begin
          state_next = S_RESP;
        end else if (!mm_in_progress && (timer >= START_SKIP)) begin
          state_next = (beat_next == BEATS_FULL) ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (timeout_hit || (beat_next == BEATS_FULL)) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      last_grant     <= 1'b1;
      beat_cnt       <= '0;
      timer          <= '0;
      mm_mask_a_rows <= '0;
      mm_mask_a_cols <= '0;
      mm_mask_b_rows <= '0;
      mm_mask_b_cols <= '0;
      rsp_id         <= 1'b0;
      rsp_dst        <= '0;
      rsp_err        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            mm_mask_a_rows <= sel_masks[CW-1 -: MASK_WIDTH];
            mm_mask_a_cols <= sel_masks[3*MASK_WIDTH-1 -: MASK_WIDTH];
            mm_mask_b_rows <= sel_masks[2*MASK_WIDTH-1 -: MASK_WIDTH];
            mm_mask_b_cols <= sel_masks[MASK_WIDTH-1:0];
            rsp_dst        <= grant ? req_dst[2*REGIDWIDTH-1:REGIDWIDTH]
                                    : req_dst[REGIDWIDTH-1:0];
            rsp_id         <= grant;
            last_grant     <= grant;
            beat_cnt       <= '0;
            timer          <= '0;
            rsp_err        <= 1'b0;
          end
        end
        S_RUN, S_DRAIN: begin
          timer    <= timer_inc;
          beat_cnt <= beat_next;
          if (state_next == S_RESP) begin
            rsp_err <= timeout_hit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_issue_ctrl.sv
// ============================================================================
// tb_matmul_issue_ctrl: randomized self-checking bench for matmul_issue_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matmul_issue_ctrl;

  localparam int RW = 8;
  localparam int MW = 8;
  localparam int NB = 8;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*RW-1:0]   req_dst;
  logic [2*4*MW-1:0] req_masks;
  logic          mm_start;
  logic          mm_in_progress;
  logic          mm_c_data_available;
  logic [MW-1:0] mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [RW-1:0] rsp_dst;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference state: who won last, and the command each requester presents.
  bit          model_last;
  logic [7:0]  cmd_dst  [2];
  logic [31:0] cmd_mask [2];

  always #5 clk = ~clk;

  matmul_issue_ctrl #(
    .REGIDWIDTH(RW), .MASK_WIDTH(MW), .MAT_MUL_SIZE(NB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_masks(req_masks),
    .mm_start(mm_start), .mm_in_progress(mm_in_progress),
    .mm_c_data_available(mm_c_data_available),
    .mm_mask_a_rows(mm_mask_a_rows), .mm_mask_a_cols(mm_mask_a_cols),
    .mm_mask_b_rows(mm_mask_b_rows), .mm_mask_b_cols(mm_mask_b_cols),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_dst(rsp_dst), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [7:0] dst, input logic [31:0] m);
    cmd_dst[r]  = dst;
    cmd_mask[r] = m;
    req_dst[r*RW +: RW]     = dst;
    req_masks[r*4*MW +: 32] = m;
  endtask

  task automatic rand_cmds();
    for (int r = 0; r < 2; r++) set_cmd(r, 8'($urandom), $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 1'b0;
    mm_in_progress = 1'b0; mm_c_data_available = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  // Matmul stand-in: busy for ip_len cycles from the first RUN cycle; n_in
  // beats in its last cycles, the rest starting gap cycles after it drops.
  function automatic bit cav_at(int k, int ip_len, int n_in, int gap);
    if (k < ip_len) return (k >= ip_len - n_in);
    return (k - ip_len >= gap) && (k - ip_len < gap + (NB - n_in));
  endfunction

  // Response cycle (relative to the first RUN cycle) and error flag.
  function automatic void model_resp(input int ip_len, input int n_in, input int gap,
                                     output int rk, output bit err);
    int beats = 0;
    bit drain = 0;
    rk = -1; err = 0;
    for (int k = 0; k < TO + 5; k++) begin
      if (cav_at(k, ip_len, n_in, gap) && beats < NB) beats++;
      if (k + 1 == TO) begin rk = k + 1; err = 1; return; end
      if (drain) begin
        if (beats == NB) begin rk = k + 1; return; end
      end else if (k >= 2 && k >= ip_len) begin
        if (beats == NB) begin rk = k + 1; return; end
        drain = 1;
      end
    end
  endfunction

  // Issues one command from an IDLE cycle, runs it to completion, holds the
  // response for 'hold' cycles, then accepts it and returns in IDLE.
  task automatic run_op(input logic [1:0] vld, input int ip_len, input int n_in,
                        input int gap, input int hold, input string tag);
    int  g, rk, rk_exp;
    bit  err_exp, start_seen, hold_bad;
    req_valid = vld; rsp_ready = 1'b0;
    mm_in_progress = 1'b0; mm_c_data_available = 1'b0;
    g = (vld == 2'b11) ? (model_last ? 0 : 1) : (vld[1] ? 1 : 0);
    #1;
    checks++;
    if (req_ready !== ((g == 1) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL %s grant: req_ready=%b required=%0d-hot", tag, req_ready, g);
    end
    tick();
    model_last = g[0];
    checks++;
    if (mm_start !== 1'b1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL %s launch: mm_start=%b req_ready=%b required 1/00", tag, mm_start, req_ready);
    end
    checks++;
    if ({mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols} !== cmd_mask[g]) begin
      errors++; $display("FAIL %s masks: got %h required %h", tag,
        {mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols}, cmd_mask[g]);
    end
    tick();
    model_resp(ip_len, n_in, gap, rk_exp, err_exp);
    rk = -1; start_seen = 0;
    for (int k = 0; k < 400; k++) begin
      mm_in_progress = (k < ip_len);
      mm_c_data_available = cav_at(k, ip_len, n_in, gap);
      tick();
      if (mm_start) start_seen = 1;
      if (rsp_valid) begin rk = k + 1; break; end
    end
    mm_c_data_available = 1'b0;
    mm_in_progress = (rk < ip_len);
    checks++;
    if (rk !== rk_exp) begin
      errors++; $display("FAIL %s latency: rsp_valid at cycle %0d required %0d", tag, rk, rk_exp);
    end
    checks++;
    if (rsp_id !== g[0] || rsp_dst !== cmd_dst[g] || rsp_err !== err_exp) begin
      errors++; $display("FAIL %s rsp: id=%b dst=%h err=%b required %0d/%h/%b",
        tag, rsp_id, rsp_dst, rsp_err, g, cmd_dst[g], err_exp);
    end
    checks++;
    if (start_seen) begin
      errors++; $display("FAIL %s stray_start: mm_start=1 required 0 during run", tag);
    end
    hold_bad = 0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (rsp_valid !== 1'b1 || req_ready !== 2'b00 || mm_start !== 1'b0) hold_bad = 1;
    end
    if (hold > 0) begin
      checks++;
      if (hold_bad) begin
        errors++; $display("FAIL %s hold: rsp_valid/req_ready/mm_start=%b/%b/%b required 1/00/0",
          tag, rsp_valid, req_ready, mm_start);
      end
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00; rsp_ready = 1'b0; mm_in_progress = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s accept: rsp_valid=%b busy=%b required 0/0", tag, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || mm_start !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: busy=%b rsp_valid=%b mm_start=%b req_ready=%b required 0",
        busy, rsp_valid, mm_start, req_ready);
    end
    checks++;
    if ({mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols, rsp_dst, rsp_id, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_regs: masks=%h dst=%h id=%b err=%b required 0",
        {mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols}, rsp_dst, rsp_id, rsp_err);
    end
  endtask

  task automatic test_single();
    set_cmd(0, 8'h12, 32'hFFFF_FFFF);
    set_cmd(1, 8'h34, 32'h0102_0304);
    run_op(2'b01, 20, 8, 0, 0, "single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_cmds();
      run_op(2'b11, $urandom_range(3, 25), $urandom_range(0, 3) + 5, $urandom_range(0, 4), 0, "b2b");
    end
  endtask

  task automatic test_drain();
    rand_cmds();
    run_op(2'b01, 12, 5, 4, 0, "drain");
  endtask

  task automatic test_random();
    int ipl;
    for (int i = 0; i < 8; i++) begin
      rand_cmds();
      ipl = $urandom_range(3, 30);
      run_op(2'($urandom_range(1, 3)), ipl, $urandom_range(0, (ipl < NB) ? ipl : NB),
             $urandom_range(0, 6), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_timeout();
    rand_cmds();
    run_op(2'b01, 100000, 0, 0, 10, "timeout");
  endtask

  task automatic test_resp_hold();
    rand_cmds();
    run_op(2'b01, 15, 8, 0, 10, "resp_hold");
  endtask

  task automatic test_reset_mid_run();
    rand_cmds();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    mm_in_progress = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mm_in_progress = 1'b0;
    model_last = 1'b1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 ||
        {mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols} !== '0) begin
      errors++; $display("FAIL mid_reset: busy=%b rsp_valid=%b masks=%h required 0",
        busy, rsp_valid, {mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols});
    end
    rand_cmds();
    run_op(2'b11, 10, 8, 0, 0, "after_reset");
  endtask

  initial begin
    req_dst = '0; req_masks = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drain();
    test_random();
    test_timeout();
    test_resp_hold();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
